// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with a hardware return-address stack.
// Supports hold/inc/jump/branch/call/return/rel-call, stall, and sticky stack-error flags.
module pc_ras_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter int unsigned      BR_SHIFT     = 2,
    parameter int unsigned      RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           stall,
    input  logic [2:0]                     PS,
    input  logic [WIDTH-1:0]               in,
    input  logic                           err_clr,
    output logic [WIDTH-1:0]               PC,
    output logic [WIDTH-1:0]               PC4,
    output logic [$clog2(RAS_DEPTH+1)-1:0] stack_depth,
    output logic                           stack_full,
    output logic                           stack_empty,
    output logic                           err_overflow,
    output logic                           err_underflow,
    output logic                           misaligned
);

    localparam int unsigned DW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [2:0] PS_HOLD   = 3'b000;
    localparam logic [2:0] PS_INC    = 3'b001;
    localparam logic [2:0] PS_JUMP   = 3'b010;
    localparam logic [2:0] PS_BRANCH = 3'b011;
    localparam logic [2:0] PS_CALL   = 3'b100;
    localparam logic [2:0] PS_RET    = 3'b101;
    localparam logic [2:0] PS_RCALL  = 3'b110;

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [WIDTH-1:0] stack_d [RAS_DEPTH];

    logic [WIDTH-1:0] pc_plus_step;
    logic [WIDTH-1:0] rel;
    logic [WIDTH-1:0] br_target;
    logic             full;
    logic             empty;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;

    // Shared datapath: sequential address, scaled relative offset, branch target.
    always_comb begin
        pc_plus_step = pc_q + STEP_W;
        rel          = in << BR_SHIFT;
        br_target    = pc_plus_step + rel;
        full         = (depth_q == DW'(RAS_DEPTH));
        empty        = (depth_q == '0);
        push_idx     = AW'(depth_q);
        pop_idx      = AW'(depth_q - DW'(1));
    end

    // Next-state: PC select, stack push/pop, sticky errors (a set beats err_clr).
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        stack_d = stack_q;
        ovf_d   = err_clr ? 1'b0 : ovf_q;
        unf_d   = err_clr ? 1'b0 : unf_q;

        if (!stall) begin
            case (PS)
                PS_HOLD:   pc_d = pc_q;
                PS_INC:    pc_d = pc_plus_step;
                PS_JUMP:   pc_d = in;
                PS_BRANCH: pc_d = br_target;
                PS_CALL, PS_RCALL: begin
                    pc_d = (PS == PS_CALL) ? in : br_target;
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        stack_d[push_idx] = pc_plus_step;
                        depth_d           = depth_q + DW'(1);
                    end
                end
                PS_RET: begin
                    if (empty) begin
                        pc_d  = pc_plus_step;
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = stack_q[pop_idx];
                        depth_d = depth_q - DW'(1);
                    end
                end
                default:   pc_d = pc_q;
            endcase
        end
    end

    // Control state; reset discards the stack by zeroing the depth.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_VECTOR;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage needs no reset: entries above depth are never read.
    always_ff @(posedge clock) begin
        stack_q <= stack_d;
    end

    always_comb begin
        PC            = pc_q;
        PC4           = pc_plus_step;
        stack_depth   = depth_q;
        stack_full    = full;
        stack_empty   = empty;
        err_overflow  = ovf_q;
        err_underflow = unf_q;
        misaligned    = |(pc_q & ALIGN_MASK);
    end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: queue-based reference model compared every
// cycle, plus directed literal expectations for the key scenarios.
module tb_pc_ras_unit;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;

    logic          clock   = 1'b0;
    logic          reset   = 1'b0;
    logic          stall   = 1'b0;
    logic [2:0]    ps      = 3'b000;
    logic [W-1:0]  in_v    = '0;
    logic          err_clr = 1'b0;

    logic [W-1:0]  pc, pc4;
    logic [2:0]    depth;
    logic          full, empty, ovf, unf, mis;

    int n_cmp  = 0;
    int n_fail = 0;

    pc_ras_unit #(
        .WIDTH(W), .STEP(4), .BR_SHIFT(2), .RAS_DEPTH(DEPTH), .RESET_VECTOR('0)
    ) dut (
        .clock(clock), .reset(reset), .stall(stall), .PS(ps), .in(in_v),
        .err_clr(err_clr), .PC(pc), .PC4(pc4), .stack_depth(depth),
        .stack_full(full), .stack_empty(empty), .err_overflow(ovf),
        .err_underflow(unf), .misaligned(mis)
    );

    always #5 clock = ~clock;

    // Reference model: a plain queue as the stack.
    logic [W-1:0] m_pc  = '0;
    logic [W-1:0] m_q[$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pc  = '0;
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (err_clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (!stall) begin
                case (ps)
                    3'd1: m_pc = m_pc + 32'd4;
                    3'd2: m_pc = in_v;
                    3'd3: m_pc = m_pc + 32'd4 + (in_v * 32'd4);
                    3'd4, 3'd6: begin
                        if (m_q.size() < DEPTH) m_q.push_back(m_pc + 32'd4);
                        else m_ovf = 1'b1;
                        m_pc = (ps == 3'd4) ? in_v : m_pc + 32'd4 + (in_v * 32'd4);
                    end
                    3'd5: begin
                        if (m_q.size() == 0) begin
                            m_pc  = m_pc + 32'd4;
                            m_unf = 1'b1;
                        end else begin
                            m_pc = m_q.pop_back();
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (reset) begin
            check("pc",     pc,            m_pc);
            check("pc4",    pc4,           m_pc + 32'd4);
            check("depth",  W'(depth),     W'(m_q.size()));
            check("full",   W'(full),      W'(m_q.size() == DEPTH));
            check("empty",  W'(empty),     W'(m_q.size() == 0));
            check("ovf",    W'(ovf),       W'(m_ovf));
            check("unf",    W'(unf),       W'(m_unf));
            check("mis",    W'(mis),       W'((m_pc % 4) != 0));
        end
    end

    task automatic step(input logic [2:0] p, input logic [W-1:0] v,
                        input logic st = 1'b0, input logic clr = 1'b0);
        ps = p; in_v = v; stall = st; err_clr = clr;
        @(posedge clock);
        #1;
        ps = 3'd0; stall = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
        check("rst_pc",    pc,        32'h0);
        check("rst_pc4",   pc4,       32'h4);
        check("rst_empty", W'(empty), 32'h1);
        check("rst_errs",  W'({ovf, unf}), 32'h0);

        step(3'd2, 32'd10);
        check("jump_pc", pc, 32'd10);
        check("jump_mis", W'(mis), 32'h1);
        step(3'd0, 32'd0);  check("hold_pc", pc, 32'd10);
        step(3'd1, 32'd0);  check("inc_pc", pc, 32'd14);
        step(3'd3, 32'd3);  check("br_fwd", pc, 32'd30);
        step(3'd3, -32'sd2); check("br_back", pc, 32'd26);
        step(3'd7, 32'h123); check("reserved_hold", pc, 32'd26);

        step(3'd2, 32'h40);
        step(3'd4, 32'h100);
        check("call_pc", pc, 32'h100);
        check("call_depth", W'(depth), 32'd1);
        step(3'd5, 32'd0);
        check("ret_pc", pc, 32'h44);
        check("ret_depth", W'(depth), 32'd0);
        step(3'd6, 32'd4);
        check("rcall_pc", pc, 32'h58);
        step(3'd5, 32'd0);
        check("rcall_ret", pc, 32'h48);

        step(3'd2, 32'h1000);
        for (int i = 2; i <= 6; i++) step(3'd4, W'(i) << 12);
        check("ovf_pc", pc, 32'h6000);
        check("ovf_depth", W'(depth), 32'd4);
        check("ovf_full", W'(full), 32'h1);
        check("ovf_flag", W'(ovf), 32'h1);
        for (int i = 4; i >= 1; i--) begin
            step(3'd5, 32'd0);
            check("pop_order", pc, (W'(i) << 12) + 32'd4);
        end
        check("pop_empty", W'(empty), 32'h1);
        step(3'd0, 32'd0, 1'b0, 1'b1);
        check("ovf_clr", W'(ovf), 32'h0);

        step(3'd2, 32'h20);
        step(3'd5, 32'd0);
        check("unf_pc", pc, 32'h24);
        check("unf_flag", W'(unf), 32'h1);
        for (int i = 0; i < 3; i++) step(3'd1, 32'd0, 1'b1);
        check("stall_pc", pc, 32'h24);
        step(3'd4, 32'h300, 1'b1);
        check("stall_call", pc, 32'h24);
        check("stall_depth", W'(depth), 32'd0);
        step(3'd0, 32'd0, 1'b1, 1'b1);
        check("stall_clr", W'(unf), 32'h0);
        step(3'd5, 32'd0, 1'b0, 1'b1);
        check("set_wins_pc", pc, 32'h28);
        check("set_wins", W'(unf), 32'h1);

        step(3'd4, 32'h80);
        check("pre_rst_depth", W'(depth), 32'd1);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_depth", W'(depth), 32'd0);
        check("async_unf", W'(unf), 32'h0);
        @(negedge clock);
        #1 reset = 1'b1;
        step(3'd5, 32'd0);
        check("post_rst_ret", pc, 32'h4);
        check("post_rst_unf", W'(unf), 32'h1);

        step(3'd2, 32'hFFFF_FFFC);
        check("wrap_pc4", pc4, 32'h0);
        step(3'd1, 32'd0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_pc4b", pc4, 32'h4);
        step(3'd2, 32'hFFFF_FFFC);
        step(3'd4, 32'h500);
        step(3'd5, 32'd0);
        check("wrap_push", pc, 32'h0);

        repeat (2) @(posedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program counter with a hardware return-address stack (RAS). It generalises the 2-bit-select PC to configurable width, step and branch scaling. It adds call/return modes, a stall input, and sticky stack-error flags. It sits at the fetch stage and drives the instruction memory address; decode drives PS and in.

Parameters:
WIDTH, 32, PC/operand width in bits
STEP, 4, sequential increment in bytes; power of 2, >=1
BR_SHIFT, 2, left shift applied to in for relative modes
RAS_DEPTH, 4, return-address stack entries; >=1
RESET_VECTOR, 0, PC value after reset

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  1 = freeze PC and stack this cycle
PS  in  3  function select (see Behaviour)
in  in  WIDTH  absolute target or signed relative offset
err_clr  in  1  synchronous clear of sticky error flags
PC  out  WIDTH  current program counter
PC4  out  WIDTH  PC+STEP, combinational, mod 2^WIDTH
stack_depth  out  $clog2(RAS_DEPTH+1)  valid entries in RAS
stack_full  out  1  stack_depth==RAS_DEPTH
stack_empty  out  1  stack_depth==0
err_overflow  out  1  sticky: call attempted while full
err_underflow  out  1  sticky: return attempted while empty
misaligned  out  1  combinational: PC low log2(STEP) bits nonzero (0 when STEP==1)

Behaviour:
- Reset (reset==0, async): PC=RESET_VECTOR, stack_depth=0, err flags=0. Stack contents are don't-care. Outputs are valid immediately; release is synchronous to clock.
- All arithmetic is WIDTH bits, wrapping mod 2^WIDTH. in is treated as two's-complement in relative modes. rel = in<<BR_SHIFT, truncated to WIDTH.
- PS encoding, applied on the rising edge when stall==0:
  000 hold: PC<=PC
  001 inc: PC<=PC+STEP
  010 jump: PC<=in
  011 branch: PC<=PC+STEP+rel
  100 call: push PC+STEP; PC<=in
  101 return: pop top; PC<=popped value
  110 rel call: push PC+STEP; PC<=PC+STEP+rel
  111 reserved: behaves as hold
- Latency: new PC is visible one clock after the select edge. PC4, flags and misaligned follow PC combinationally.
- Stack is LIFO. Push writes entry[stack_depth] and increments the depth. Pop reads entry[stack_depth-1] and decrements the depth.
- Call when full: PC still loads the target. The push is dropped, depth is unchanged, and err_overflow<=1.
- Return when empty: PC<=PC+STEP, depth stays 0, and err_underflow<=1.
- stall==1: PC, stack and depth are all held, regardless of PS. Errors are not set. err_clr still acts.
- err_clr==1 clears both error flags on the edge. If an error event occurs on the same edge, the set wins.
- Misaligned targets are loaded as-is; no trap is raised. misaligned only reports them.
- reset asserted mid-sequence discards all stack contents at once. The first post-reset return underflows.

Test Plan:
- Reset then release, PS=000 -> PC=0, PC4=4, stack_empty=1, all errors 0. PS=010, in=10 -> PC=10 next cycle, misaligned=1.
- From PC=10: PS=000 for one cycle -> PC=10. PS=001 -> PC=14. PS=011 with in=3 -> PC=30 (14+4+12). PS=011 with in=-2 -> PC=26 (30+4-8).
- Call/return from PC=0x40: PS=100, in=0x100 -> PC=0x100, depth=1. Then PS=101 -> PC=0x44, depth=0. PS=110 with in=4 from 0x44 -> PC=0x58, top entry=0x48.
- Five calls from empty (RAS_DEPTH=4) -> depth saturates at 4, stack_full=1, err_overflow=1 after the fifth. Four returns then pop the first four return addresses in reverse order. err_clr -> err_overflow=0.
- Return when empty at PC=0x20 -> PC=0x24, err_underflow=1. stall=1 with PS=001 held for 3 cycles -> PC unchanged. reset pulsed low asynchronously mid-cycle -> PC=0 before the next edge.
- Wrap: PS=010, in=0xFFFFFFFC, then PS=001 -> PC=0, PC4=4. Call at that address pushes 0x00000000.
